priority_encoder: RTL and testbench
===================================

// Module: priority_encoder
// PURPOSE
// - Registered N-to-log2(N) priority encoder: reports the index of the highest-set bit of
//   `data` one clock later.
// - A `valid` flag separates "bit 0 set" from "no bit set".
// - Generic arbitration / interrupt-index building block; default config is 4-to-2.
// PARAMETERS
// - WIDTH  4  number of request bits on `data`; legal range 2..64.
// - YW  $clog2(WIDTH)  width of encoded index `y`; derived, not overridden.
// PORTS
// - clk    input   1      single clock; all state updates on rising edge
// - rst_n  input   1      synchronous, active-low reset (sampled on rising clk)
// - data   input   WIDTH  request vector; bit WIDTH-1 = highest priority
// - y      output  YW     index of highest set bit in data, registered
// - valid  output  1      1 when the registered data had at least one bit set
// BEHAVIOUR
// - Clocking: one clock, `clk`. Reset is synchronous, active-low on `rst_n`.
//   - `rst_n` is sampled only at the rising edge of `clk`; no asynchronous path.
// - Reset: while rst_n==0 at a rising edge, y <= 0 and valid <= 0. Reset overrides data.
// - Encode rule: y = largest i such that data[i]==1. Lower set bits are ignored.
//   - Default WIDTH=4: 1xxx->11, 01xx->10, 001x->01, 0001->00.
// - Empty input: data==0 -> y <= 0, valid <= 0.
//   - y==0 with valid==0 means "no request"; y==0 with valid==1 means bit 0.
// - Latency: exactly 1 cycle.
//   - data sampled at edge k appears on y/valid after edge k, held until edge k+1.
//   - No handshake, no stall: a new vector is accepted every cycle.
// - Outputs are pure flop outputs: no combinational path from data to y/valid.
// - Reset mid-operation: the first edge with rst_n==0 clears outputs.
//   - The first edge with rst_n==1 registers the encode of the data present at that edge.
// - Any X/Z on data is don't-care for synthesis; no X-masking logic.
// - Non-power-of-2 WIDTH:
//   - y never exceeds WIDTH-1.
//   - Unused high codes are unreachable.
// STRUCTURE
// - Combinational core sub-module `priority_encoder_core` (params WIDTH, YW).
//   - Implemented as a for-loop scan from LSB to MSB; the last hit wins.
//   - Outputs idx[YW-1:0] and any.
// - Top level = core + one register stage for {y, valid} with sync reset.
// - No shared package needed.
//   - YW is derived locally via $clog2.
//   - If the codebase keeps a common util package, place a clog2 helper there.
// TESTING
// - Reset: rst_n=0 for 2 edges with data=4'b1111 -> y==2'b00, valid==0.
//   - After release, the next edge gives y==2'b11, valid==1.
// - One-hot sweep (WIDTH=4), one per cycle:
//   - data = 0001, 0010, 0100, 1000 -> y = 00, 01, 10, 11, each valid=1.
//   - Each result appears one cycle after its input.
// - Empty: data=4'b0000 -> y==2'b00, valid==0.
//   - Also data=4'b0001 -> y==2'b00, valid==1 (valid distinguishes the two cases).
// - Priority with multiple bits set:
//   - 1111->11, 1100->11, 0011->01, 0110->10, 0101->10; all valid=1.
// - Latency/back-to-back: change data every cycle with a random 4-bit vector for 200 cycles.
//   - Compare against a model delayed by 1 cycle.
//   - Outputs must not change between edges.
// - Parameter: WIDTH=5 (YW=3).
//   - data=5'b10000->y=3'd4; 5'b01010->3'd3; 5'b00000->y=0, valid=0.

Source files
------------

// File: rtl/priority_encoder_pkg.sv
// Shared helpers for the priority encoder: default configuration and index-width calculation.
package priority_encoder_pkg;

    localparam int unsigned PE_DEFAULT_WIDTH = 4;
    localparam int unsigned PE_MIN_WIDTH     = 2;
    localparam int unsigned PE_MAX_WIDTH     = 64;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned pe_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/priority_encoder_core.sv
// Combinational highest-set-bit scan; an LSB-to-MSB loop where the last hit wins.
module priority_encoder_core
    import priority_encoder_pkg::*;
#(
    parameter int unsigned WIDTH = PE_DEFAULT_WIDTH,
    parameter int unsigned YW    = pe_clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic [YW-1:0]    idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (data[i]) begin
                idx = YW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder.sv
// Registered priority encoder: index of highest set bit of data, plus valid, one clock later.
module priority_encoder
    import priority_encoder_pkg::*;
#(
    parameter int unsigned WIDTH = PE_DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           data,
    output logic [pe_clog2(WIDTH)-1:0] y,
    output logic                       valid
);

    localparam int unsigned YW = pe_clog2(WIDTH);

    logic [YW-1:0] y_d;
    logic          valid_d;
    logic [YW-1:0] y_q;
    logic          valid_q;

    priority_encoder_core #(
        .WIDTH (WIDTH),
        .YW    (YW)
    ) u_core (
        .data (data),
        .idx  (y_d),
        .any  (valid_d)
    );

    // Single output stage; reset takes precedence over the incoming vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Directed and random checks of the registered priority encoder at WIDTH=4 and WIDTH=5.
`timescale 1ns/1ps
module tb_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] data4;
    logic [1:0] y4;
    logic       valid4;
    logic [4:0] data5;
    logic [2:0] y5;
    logic       valid5;

    int n_checks;
    int n_fail;

    priority_encoder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data4),
        .y     (y4),
        .valid (valid4)
    );

    priority_encoder #(.WIDTH(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data5),
        .y     (y5),
        .valid (valid5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: scan from MSB down, first hit wins; returns {valid, idx}.
    function automatic logic [3:0] ref_enc(input logic [7:0] d, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (d[i]) return {1'b1, 3'(i)};
        end
        return 4'b0000;
    endfunction

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        data4 = 4'b1111;
        data5 = 5'b11111;
        for (int k = 0; k < 2; k++) begin
            edge_sample();
            n_checks++;
            if (y4 !== 2'b00 || valid4 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: y=%b valid=%b, required y=00 valid=0", k, y4, valid4);
            end
            n_checks++;
            if (y5 !== 3'd0 || valid5 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold5[%0d]: y=%0d valid=%b, required y=0 valid=0", k, y5, valid5);
            end
        end
        rst_n = 1'b1;
        edge_sample();
        n_checks++;
        if (y4 !== 2'b11 || valid4 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: y=%b valid=%b, required y=11 valid=1", y4, valid4);
        end
    endtask

    task automatic test_onehot();
        logic [3:0] vec [4];
        logic [1:0] exp_y [4];
        vec = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_y = '{2'b00, 2'b01, 2'b10, 2'b11};
        for (int k = 0; k < 4; k++) begin
            data4 = vec[k];
            edge_sample();
            n_checks++;
            if (y4 !== exp_y[k] || valid4 !== 1'b1) begin
                n_fail++;
                $display("FAIL onehot %b: y=%b valid=%b, required y=%b valid=1", vec[k], y4, valid4, exp_y[k]);
            end
        end
    endtask

    task automatic test_empty();
        data4 = 4'b0000;
        edge_sample();
        n_checks++;
        if (y4 !== 2'b00 || valid4 !== 1'b0) begin
            n_fail++;
            $display("FAIL empty: y=%b valid=%b, required y=00 valid=0", y4, valid4);
        end
        data4 = 4'b0001;
        edge_sample();
        n_checks++;
        if (y4 !== 2'b00 || valid4 !== 1'b1) begin
            n_fail++;
            $display("FAIL bit0: y=%b valid=%b, required y=00 valid=1", y4, valid4);
        end
    endtask

    task automatic test_priority();
        logic [3:0] vec [5];
        logic [1:0] exp_y [5];
        vec = '{4'b1111, 4'b1100, 4'b0011, 4'b0110, 4'b0101};
        exp_y = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b10};
        for (int k = 0; k < 5; k++) begin
            data4 = vec[k];
            edge_sample();
            n_checks++;
            if (y4 !== exp_y[k] || valid4 !== 1'b1) begin
                n_fail++;
                $display("FAIL priority %b: y=%b valid=%b, required y=%b valid=1", vec[k], y4, valid4, exp_y[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        logic [1:0] y_seen;
        logic       v_seen;
        data4 = 4'($urandom);
        for (int k = 0; k < 200; k++) begin
            exp = ref_enc({4'b0, data4}, 4);
            edge_sample();
            n_checks++;
            if (y4 !== exp[1:0] || valid4 !== exp[3]) begin
                n_fail++;
                $display("FAIL b2b[%0d] data=%b: y=%b valid=%b, required y=%b valid=%b",
                         k, data4, y4, valid4, exp[1:0], exp[3]);
            end
            y_seen = y4;
            v_seen = valid4;
            data4  = 4'($urandom);
            #4;
            n_checks++;
            if (y4 !== y_seen || valid4 !== v_seen) begin
                n_fail++;
                $display("FAIL b2b_stable[%0d]: y=%b valid=%b moved mid-cycle, required y=%b valid=%b",
                         k, y4, valid4, y_seen, v_seen);
            end
        end
    endtask

    task automatic test_width5();
        logic [4:0] vec [3];
        logic [2:0] exp_y [3];
        logic       exp_v [3];
        vec   = '{5'b10000, 5'b01010, 5'b00000};
        exp_y = '{3'd4, 3'd3, 3'd0};
        exp_v = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            data5 = vec[k];
            edge_sample();
            n_checks++;
            if (y5 !== exp_y[k] || valid5 !== exp_v[k]) begin
                n_fail++;
                $display("FAIL width5 %b: y=%0d valid=%b, required y=%0d valid=%b",
                         vec[k], y5, valid5, exp_y[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        data4 = 4'b0100;
        edge_sample();
        rst_n = 1'b0;
        data4 = 4'b1000;
        edge_sample();
        n_checks++;
        if (y4 !== 2'b00 || valid4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: y=%b valid=%b, required y=00 valid=0", y4, valid4);
        end
        rst_n = 1'b1;
        data4 = 4'b0010;
        edge_sample();
        n_checks++;
        if (y4 !== 2'b01 || valid4 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_release: y=%b valid=%b, required y=01 valid=1", y4, valid4);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        data4    = 4'b0000;
        data5    = 5'b00000;
        test_reset();
        test_onehot();
        test_empty();
        test_priority();
        test_back_to_back();
        test_width5();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
